// File: rtl/mmu_seq_ctrl.sv
// mmu_seq_ctrl: sequencer for one systolic-array tile pass.
// Preloads PE_SIZE ifmap vectors, streams len weight vectors with
// diagonally skewed per-lane enables, then tracks the psum vectors
// leaving the array and raises a one-cycle done pulse.
// The buffers have 1-cycle read latency, so every enable below is
// derived from the read strobe delayed by one cycle (base_v).
module mmu_seq_ctrl #(
  parameter int PE_SIZE    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10,
  parameter int OUT_LAT    = 2 * PE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ifmap_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ifmap_rd_addr_o,
  output logic                  weight_rd_en_o,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr_o,
  output logic                  ifmap_preload_o,
  output logic [PE_SIZE-1:0]    weight_en_col_o,
  output logic [PE_SIZE-1:0]    psum_en_row_o,
  output logic                  psum_valid_o,
  output logic [ADDR_WIDTH-1:0] psum_wr_addr_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] IFMAP_LAST = ADDR_WIDTH'(PE_SIZE - 1);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ifmap_rd_en_q, ifmap_rd_en_d;
  logic [ADDR_WIDTH-1:0]   ifmap_rd_addr_q, ifmap_rd_addr_d;
  logic                    weight_rd_en_q, weight_rd_en_d;
  logic [ADDR_WIDTH-1:0]   weight_rd_addr_q, weight_rd_addr_d;
  logic                    preload_q, preload_d;
  logic [PE_SIZE-1:0]      skew_q, skew_d;
  logic [OUT_LAT-1:0]      lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]   psum_wr_addr_q, psum_wr_addr_d;
  logic [LEN_WIDTH-1:0]    psum_cnt_q, psum_cnt_d;
  logic [ADDR_WIDTH-1:0]   weight_last;
  logic                    start_accept;
  logic                    base_v;
  logic                    psum_valid_q;
  logic [PE_SIZE-1:0]      lane_bus;

  // Start is only honoured in IDLE; a held start_i in DONE is ignored.
  assign start_accept = (state_q == IDLE) && start_i;
  assign weight_last  = ADDR_WIDTH'(len_q - LEN_WIDTH'(1));
  assign base_v       = skew_q[0];
  assign psum_valid_q = lat_q[OUT_LAT-1];

  // State register plus every registered output and datapath flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      len_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      ifmap_rd_en_q    <= 1'b0;
      ifmap_rd_addr_q  <= '0;
      weight_rd_en_q   <= 1'b0;
      weight_rd_addr_q <= '0;
      preload_q        <= 1'b0;
      skew_q           <= '0;
      lat_q            <= '0;
      psum_wr_addr_q   <= '0;
      psum_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      ifmap_rd_en_q    <= ifmap_rd_en_d;
      ifmap_rd_addr_q  <= ifmap_rd_addr_d;
      weight_rd_en_q   <= weight_rd_en_d;
      weight_rd_addr_q <= weight_rd_addr_d;
      preload_q        <= preload_d;
      skew_q           <= skew_d;
      lat_q            <= lat_d;
      psum_wr_addr_q   <= psum_wr_addr_d;
      psum_cnt_q       <= psum_cnt_d;
    end
  end

  // Next-state logic: preload and stream end on their last address,
  // drain ends once the psum count (including this cycle) reaches len.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? DONE : PRELOAD;
        end
      end
      PRELOAD: begin
        if (ifmap_rd_addr_q == IFMAP_LAST) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (weight_rd_addr_q == weight_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (psum_cnt_d == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: strobes follow the upcoming state so they are
  // registered and line up with that state's cycles.
  always_comb begin
    busy_d           = (state_d != IDLE);
    done_d           = (state_d == DONE);
    ifmap_rd_en_d    = (state_d == PRELOAD);
    weight_rd_en_d   = (state_d == STREAM);
    preload_d        = (state_q == PRELOAD) && (ifmap_rd_addr_q == '0);
    ifmap_rd_addr_d  = ifmap_rd_addr_q;
    weight_rd_addr_d = weight_rd_addr_q;
    if (state_d == PRELOAD) begin
      ifmap_rd_addr_d = (state_q == PRELOAD) ? ifmap_rd_addr_q + ADDR_WIDTH'(1) : '0;
    end
    if (state_d == STREAM) begin
      weight_rd_addr_d = (state_q == STREAM) ? weight_rd_addr_q + ADDR_WIDTH'(1) : '0;
    end
  end

  // Tile length is captured only when a start is accepted.
  always_comb begin
    len_d = len_q;
    if (start_accept) begin
      len_d = len_i;
    end
  end

  // Skew chain: stage 0 is base_v, stage i is base_v delayed i cycles.
  always_comb begin
    skew_d    = '0;
    skew_d[0] = weight_rd_en_q;
    for (int i = 1; i < PE_SIZE; i++) begin
      skew_d[i] = skew_q[i-1];
    end
  end

  // Array latency line: the last stage is base_v delayed OUT_LAT cycles.
  always_comb begin
    lat_d    = '0;
    lat_d[0] = base_v;
    for (int k = 1; k < OUT_LAT; k++) begin
      lat_d[k] = lat_q[k-1];
    end
  end

  // Psum write address and count restart per pass and advance after
  // each valid output cycle.
  always_comb begin
    psum_wr_addr_d = psum_wr_addr_q;
    psum_cnt_d     = psum_cnt_q;
    if (start_accept) begin
      psum_wr_addr_d = '0;
      psum_cnt_d     = '0;
    end else if (psum_valid_q) begin
      psum_wr_addr_d = psum_wr_addr_q + ADDR_WIDTH'(1);
      psum_cnt_d     = psum_cnt_q + LEN_WIDTH'(1);
    end
  end

  // Lane i is driven by bus bit PE_SIZE-1-i, so lane 0 is the MSB.
  always_comb begin
    lane_bus = '0;
    for (int i = 0; i < PE_SIZE; i++) begin
      lane_bus[PE_SIZE-1-i] = skew_q[i];
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign ifmap_rd_en_o    = ifmap_rd_en_q;
  assign ifmap_rd_addr_o  = ifmap_rd_addr_q;
  assign weight_rd_en_o   = weight_rd_en_q;
  assign weight_rd_addr_o = weight_rd_addr_q;
  assign ifmap_preload_o  = preload_q;
  assign weight_en_col_o  = lane_bus;
  assign psum_en_row_o    = lane_bus;
  assign psum_valid_o     = psum_valid_q;
  assign psum_wr_addr_o   = psum_wr_addr_q;

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// tb_mmu_seq_ctrl: directed bench for the tile-pass sequencer.
// A cycle-offset model predicts every output each cycle from the pass
// start cycle and length; directed literal checks pin that model.
module tb_mmu_seq_ctrl;

  localparam int P  = 4;
  localparam int AW = 10;
  localparam int LW = 10;
  localparam int OL = 2 * P;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic          ifmap_rd_en_o;
  logic [AW-1:0] ifmap_rd_addr_o;
  logic          weight_rd_en_o;
  logic [AW-1:0] weight_rd_addr_o;
  logic          ifmap_preload_o;
  logic [P-1:0]  weight_en_col_o;
  logic [P-1:0]  psum_en_row_o;
  logic          psum_valid_o;
  logic [AW-1:0] psum_wr_addr_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int rel_now  = 0;

  mmu_seq_ctrl #(
    .PE_SIZE(P), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .OUT_LAT(OL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .ifmap_rd_en_o(ifmap_rd_en_o), .ifmap_rd_addr_o(ifmap_rd_addr_o),
    .weight_rd_en_o(weight_rd_en_o), .weight_rd_addr_o(weight_rd_addr_o),
    .ifmap_preload_o(ifmap_preload_o),
    .weight_en_col_o(weight_en_col_o), .psum_en_row_o(psum_en_row_o),
    .psum_valid_o(psum_valid_o), .psum_wr_addr_o(psum_wr_addr_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive a start request just after a rising edge; the following
  // falling edge is cycle 0 of the pass.
  task automatic applyStimulus(input logic s, input int l);
    @(posedge clk);
    #1;
    start_i = s;
    len_i   = LW'(l);
    @(negedge clk);
    rel_now = 0;
  endtask

  // Advance to the falling edge of pass cycle k.
  task automatic goRel(input int k);
    while (rel_now < k) begin
      @(negedge clk);
      rel_now++;
    end
  endtask

  task automatic dropStart();
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Model: derive every output from the offset to the accepted start.
  int cyc = 0;
  bit act = 1'b0;
  int t0, mlen;
  int last_if = 0, last_wt = 0, last_ps = 0;

  always @(negedge clk) begin
    int rel, dn;
    int e_busy, e_done, e_if_en, e_if_addr, e_wt_en, e_wt_addr;
    int e_pre, e_lanes, e_pv, e_ps;
    rel = 0;
    dn  = 0;
    if (!rst_n) begin
      act = 1'b0; last_if = 0; last_wt = 0; last_ps = 0;
    end else if (act) begin
      rel = cyc - t0;
      dn  = (mlen == 0) ? 1 : P + 2 + OL + mlen;
      if (rel > dn) begin
        if (mlen != 0) begin
          last_if = P - 1; last_wt = mlen - 1; last_ps = mlen;
        end else begin
          last_ps = 0;
        end
        act = 1'b0;
      end
    end
    e_busy = 0; e_done = 0; e_if_en = 0; e_wt_en = 0; e_pre = 0;
    e_lanes = 0; e_pv = 0;
    e_if_addr = last_if; e_wt_addr = last_wt; e_ps = last_ps;
    if (act && mlen == 0) begin
      e_busy = (rel == 1); e_done = (rel == 1); e_ps = 0;
    end else if (act) begin
      e_busy    = (rel >= 1 && rel <= dn);
      e_done    = (rel == dn);
      e_if_en   = (rel >= 1 && rel <= P);
      e_if_addr = (rel - 1 < P - 1) ? rel - 1 : P - 1;
      e_pre     = (rel == 2);
      e_wt_en   = (rel >= P + 1 && rel <= P + mlen);
      if (rel >= P + 1) e_wt_addr = (rel - P - 1 < mlen - 1) ? rel - P - 1 : mlen - 1;
      for (int i = 0; i < P; i++) begin
        if (rel >= P + 2 + i && rel <= P + 1 + i + mlen) e_lanes |= (1 << (P - 1 - i));
      end
      e_pv = (rel >= P + 2 + OL && rel <= P + 1 + OL + mlen);
      if (rel < P + 2 + OL) e_ps = 0;
      else e_ps = (rel - (P + 2 + OL) < mlen) ? rel - (P + 2 + OL) : mlen;
    end
    checkOutput("m_busy", 32'(busy_o), e_busy);
    checkOutput("m_done", 32'(done_o), e_done);
    checkOutput("m_if_en", 32'(ifmap_rd_en_o), e_if_en);
    checkOutput("m_if_addr", 32'(ifmap_rd_addr_o), e_if_addr);
    checkOutput("m_wt_en", 32'(weight_rd_en_o), e_wt_en);
    checkOutput("m_wt_addr", 32'(weight_rd_addr_o), e_wt_addr);
    checkOutput("m_preload", 32'(ifmap_preload_o), e_pre);
    checkOutput("m_col", 32'(weight_en_col_o), e_lanes);
    checkOutput("m_row", 32'(psum_en_row_o), e_lanes);
    checkOutput("m_pvalid", 32'(psum_valid_o), e_pv);
    checkOutput("m_paddr", 32'(psum_wr_addr_o), e_ps);
    if (rst_n && e_busy == 0 && start_i === 1'b1) begin
      act = 1'b1; t0 = cyc; mlen = int'(len_i);
    end
    cyc++;
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    rst_n = 1'b0; start_i = 1'b0; len_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy_o), 0);
    checkOutput("idle_if_en", 32'(ifmap_rd_en_o), 0);

    $display("[TB] len=3 pass, start held high");
    applyStimulus(1'b1, 3);
    goRel(1);  checkOutput("a_if_en1", 32'(ifmap_rd_en_o), 1);
               checkOutput("a_if_addr1", 32'(ifmap_rd_addr_o), 0);
               checkOutput("a_busy1", 32'(busy_o), 1);
    goRel(2);  checkOutput("a_preload2", 32'(ifmap_preload_o), 1);
    goRel(4);  checkOutput("a_if_addr4", 32'(ifmap_rd_addr_o), 3);
    goRel(5);  checkOutput("a_wt_en5", 32'(weight_rd_en_o), 1);
               checkOutput("a_wt_addr5", 32'(weight_rd_addr_o), 0);
    goRel(6);  checkOutput("a_col6", 32'(weight_en_col_o), 4'b1000);
    goRel(7);  checkOutput("a_wt_addr7", 32'(weight_rd_addr_o), 2);
    goRel(9);  checkOutput("a_col9", 32'(weight_en_col_o), 4'b0111);
    goRel(11); checkOutput("a_row11", 32'(psum_en_row_o), 4'b0001);
    goRel(14); checkOutput("a_pv14", 32'(psum_valid_o), 1);
               checkOutput("a_pa14", 32'(psum_wr_addr_o), 0);
    goRel(16); checkOutput("a_pa16", 32'(psum_wr_addr_o), 2);
    goRel(17); checkOutput("a_done17", 32'(done_o), 1);
               checkOutput("a_busy17", 32'(busy_o), 1);
    goRel(18); checkOutput("a_busy18", 32'(busy_o), 0);
               checkOutput("a_done18", 32'(done_o), 0);
    dropStart();
    goRel(19); checkOutput("a_busy19", 32'(busy_o), 1);
               checkOutput("a_if_addr19", 32'(ifmap_rd_addr_o), 0);
    goRel(40);

    $display("[TB] len=0 pass");
    applyStimulus(1'b1, 0);
    dropStart();
    goRel(1);  checkOutput("b_done1", 32'(done_o), 1);
               checkOutput("b_busy1", 32'(busy_o), 1);
               checkOutput("b_wt_en1", 32'(weight_rd_en_o), 0);
    goRel(2);  checkOutput("b_busy2", 32'(busy_o), 0);
    goRel(6);

    $display("[TB] len=1 pass");
    applyStimulus(1'b1, 1);
    dropStart();
    goRel(6);  checkOutput("c_col6", 32'(weight_en_col_o), 4'b1000);
    goRel(7);  checkOutput("c_col7", 32'(weight_en_col_o), 4'b0100);
    goRel(8);  checkOutput("c_col8", 32'(weight_en_col_o), 4'b0010);
    goRel(9);  checkOutput("c_col9", 32'(weight_en_col_o), 4'b0001);
               checkOutput("c_row9", 32'(psum_en_row_o), 4'b0001);
    goRel(14); checkOutput("c_pv14", 32'(psum_valid_o), 1);
               checkOutput("c_pa14", 32'(psum_wr_addr_o), 0);
    goRel(15); checkOutput("c_pv15", 32'(psum_valid_o), 0);
               checkOutput("c_done15", 32'(done_o), 1);
    goRel(20);

    $display("[TB] len=3 pass with reset at cycle 10");
    applyStimulus(1'b1, 3);
    dropStart();
    goRel(9);  checkOutput("d_col9", 32'(weight_en_col_o), 4'b0111);
    @(posedge clk);
    #2 rst_n = 1'b0;
    goRel(10); checkOutput("d_col10", 32'(weight_en_col_o), 0);
               checkOutput("d_busy10", 32'(busy_o), 0);
               checkOutput("d_if_addr10", 32'(ifmap_rd_addr_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 2);
    dropStart();
    goRel(14); checkOutput("e_pv14", 32'(psum_valid_o), 1);
               checkOutput("e_pa14", 32'(psum_wr_addr_o), 0);
    goRel(15); checkOutput("e_pa15", 32'(psum_wr_addr_o), 1);
    goRel(16); checkOutput("e_done16", 32'(done_o), 1);
               checkOutput("e_pa16", 32'(psum_wr_addr_o), 2);
    goRel(20);

    $display("[TB] len=9 pass, stream overlaps drain");
    applyStimulus(1'b1, 9);
    dropStart();
    goRel(23); checkOutput("f_done23", 32'(done_o), 1);
               checkOutput("f_pa23", 32'(psum_wr_addr_o), 9);
    goRel(30);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/mmu_seq_ctrl.md
Name: mmu_seq_ctrl

Overview:
- Sequencer for one systolic-array tile pass. On start it reads PE_SIZE ifmap vectors from the ifmap buffer and pulses the array preload.
- It then streams LEN weight vectors from the weight buffer, generating the diagonally skewed per-lane weight and psum enables.
- It flags the psum vectors leaving the array with write addresses, then reports done.
- It sits between the top-level layer controller and the MMU plus its SRAM buffers, which have 1-cycle read latency.

Parameters:
- PE_SIZE, 4, array dimension; number of ifmap vectors preloaded and number of skew lanes.
- ADDR_WIDTH, 10, buffer address width.
- LEN_WIDTH, 10, width of the tile length (count of weight vectors).
- OUT_LAT, 2*PE_SIZE, cycles from base-valid to a psum vector leaving the array.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  start request; sampled only in IDLE
- len_i  in  LEN_WIDTH  number of weight vectors; latched at start
- busy_o  out  1  high from the first cycle after an accepted start through the done cycle
- done_o  out  1  one-cycle completion pulse
- ifmap_rd_en_o  out  1  ifmap buffer read strobe
- ifmap_rd_addr_o  out  ADDR_WIDTH  ifmap read address
- weight_rd_en_o  out  1  weight buffer read strobe
- weight_rd_addr_o  out  ADDR_WIDTH  weight read address
- ifmap_preload_o  out  1  one-cycle preload start pulse to the array
- weight_en_col_o  out  PE_SIZE  skewed weight enables; bit PE_SIZE-1-i drives lane i
- psum_en_row_o  out  PE_SIZE  skewed psum enables; same bit mapping and timing as weight_en_col_o
- psum_valid_o  out  1  a psum vector is leaving the array this cycle
- psum_wr_addr_o  out  ADDR_WIDTH  output buffer write address, valid with psum_valid_o

Behaviour:
- Reset (asynchronous, also mid-operation): FSM to IDLE; all outputs 0; all counters, latched len and skew/latency shift registers cleared. No further reads or enables are issued.
- FSM states: IDLE, PRELOAD, STREAM, DRAIN, DONE.
- IDLE: start_i=1 at cycle T latches len_i.
  - len_i=0: go to DONE at T+1 with no reads or enables.
  - Otherwise: go to PRELOAD at T+1.
- start_i is ignored in every state other than IDLE, including DONE.
- PRELOAD: cycles T+1..T+PE_SIZE.
  - ifmap_rd_en_o=1 with addresses 0..PE_SIZE-1, one per cycle.
  - ifmap_preload_o=1 at T+2 only, aligned with the first ifmap data.
  - Then go to STREAM.
- STREAM: starts at S=T+PE_SIZE+1 and runs for cycles S..S+len-1.
  - weight_rd_en_o=1 with addresses 0..len-1.
  - Then go to DRAIN.
  - The first weight data arrives at S+1, the cycle after the last ifmap data.
- Enable generation:
  - base_v = weight_rd_en_o delayed 1 cycle.
  - Lane i enable (both buses) = base_v delayed i cycles, i=0..PE_SIZE-1, via a shift register.
- Output generation:
  - psum_valid_o = base_v delayed OUT_LAT cycles.
  - psum_wr_addr_o starts at 0 and increments after each valid cycle.
- DRAIN: wait until the psum write count equals len, evaluated after the last valid cycle. Then go to DONE.
- DONE: done_o=1 for one cycle, busy_o=1. Next cycle go to IDLE, busy_o=0.
- All outputs are registered. Addresses hold their last value when the read enable is low. Counters never wrap within a pass because len ≤ 2^LEN_WIDTH-1 ≤ address range.

Test Plan:
- Reset then idle: all outputs 0; start_i held 0 for 20 cycles -> no reads, busy_o=0.
- PE_SIZE=4, start at cycle 0, len=3:
  - ifmap reads at cycles 1–4, addresses 0–3; preload pulse at cycle 2.
  - Weight reads at cycles 5–7, addresses 0–2.
  - Lane0 enable at cycles 6–8; lane3 enable at cycles 9–11.
  - psum_valid at cycles 14–16, write addresses 0–2.
  - done_o at cycle 17; busy_o low at 18.
- Start held high through the whole pass in that run -> second pass accepted only at cycle 18 (IDLE), not at cycle 17 (DONE).
- len=0 at cycle 0 -> done_o at cycle 1; no read or enable ever asserted.
- len=1 -> weight_en_col_o walks 4'b1000, 0100, 0010, 0001 over cycles 6–9; single psum_valid at 14, address 0.
- rst_n low at cycle 10 of a len=3 pass -> all outputs 0 immediately; restart with len=2 -> write addresses begin at 0.
